// File: rtl/mux8_32.sv
// Byte-to-word assembler: gathers four consecutive valid bytes on clk_4f into one
// 32-bit word, pulsing valid_out on completion and frame_err when a word is abandoned.
module mux8_32 #(
    parameter int MSB_FIRST = 1
) (
    input  logic        clk_4f,
    input  logic        reset,
    input  logic [7:0]  data_in,
    input  logic        valid_in,
    output logic [31:0] data_out,
    output logic        valid_out,
    output logic        frame_err,
    output logic [1:0]  byte_cnt
);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t      state_r, state_s;
    logic [23:0] asm_r, asm_s;
    logic [31:0] data_s;
    logic        valid_s;
    logic        err_s;
    logic [1:0]  cnt_s;

    // Pushing each new byte in from the "later" end keeps earlier bytes in order.
    function automatic logic [23:0] shift_in(input logic [23:0] held, input logic [7:0] b);
        if (MSB_FIRST != 0) begin
            return {held[15:0], b};
        end else begin
            return {b, held[23:8]};
        end
    endfunction

    function automatic logic [31:0] make_word(input logic [23:0] held, input logic [7:0] b);
        if (MSB_FIRST != 0) begin
            return {held, b};
        end else begin
            return {b, held};
        end
    endfunction

    // State, assembly register and registered outputs.
    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            asm_r     <= 24'h00_0000;
            data_out  <= 32'h0000_0000;
            valid_out <= 1'b0;
            frame_err <= 1'b0;
            byte_cnt  <= 2'd0;
        end else begin
            state_r   <= state_s;
            asm_r     <= asm_s;
            data_out  <= data_s;
            valid_out <= valid_s;
            frame_err <= err_s;
            byte_cnt  <= cnt_s;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_s = state_r;
        asm_s   = asm_r;
        data_s  = data_out;
        valid_s = 1'b0;
        err_s   = 1'b0;
        cnt_s   = byte_cnt;
        case (state_r)
            IDLE: begin
                if (valid_in) begin
                    asm_s   = shift_in(24'h00_0000, data_in);
                    cnt_s   = 2'd1;
                    state_s = COLLECT;
                end else begin
                    cnt_s   = 2'd0;
                end
            end
            COLLECT: begin
                if (valid_in) begin
                    if (byte_cnt == 2'd3) begin
                        data_s  = make_word(asm_r, data_in);
                        valid_s = 1'b1;
                        cnt_s   = 2'd0;
                        state_s = IDLE;
                    end else begin
                        asm_s   = shift_in(asm_r, data_in);
                        cnt_s   = byte_cnt + 2'd1;
                    end
                end else begin
                    // Gap mid-word: drop the partial word, keep the last good one.
                    asm_s   = 24'h00_0000;
                    err_s   = 1'b1;
                    cnt_s   = 2'd0;
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
                asm_s   = 24'h00_0000;
                cnt_s   = 2'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_mux8_32.sv
// Scoreboard bench for mux8_32: directed byte streams, expected words queued by the
// driver and popped by an independent monitor on every valid_out pulse.
module tb_mux8_32;

    logic        clk_4f = 1'b0;
    logic        reset;
    logic [7:0]  data_in;
    logic        valid_in;
    logic [31:0] data_out, data_out_l;
    logic        valid_out, valid_out_l;
    logic        frame_err, frame_err_l;
    logic [1:0]  byte_cnt, byte_cnt_l;

    int total = 0;
    int bad   = 0;
    int err_seen = 0;
    logic [31:0] q_m[$];
    logic [31:0] q_l[$];

    mux8_32 #(.MSB_FIRST(1)) dut (
        .clk_4f(clk_4f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .data_out(data_out), .valid_out(valid_out), .frame_err(frame_err), .byte_cnt(byte_cnt)
    );

    mux8_32 #(.MSB_FIRST(0)) dut_l (
        .clk_4f(clk_4f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .data_out(data_out_l), .valid_out(valid_out_l), .frame_err(frame_err_l), .byte_cnt(byte_cnt_l)
    );

    always #5 clk_4f = ~clk_4f;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] swap_bytes(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    task automatic expect_word(input logic [31:0] w);
        q_m.push_back(w);
        q_l.push_back(swap_bytes(w));
    endtask

    task automatic send(input logic [7:0] b, input logic v);
        @(negedge clk_4f);
        data_in  = b;
        valid_in = v;
        @(posedge clk_4f);
        #1;
    endtask

    task automatic idle_cycle();
        send(8'h00, 1'b0);
    endtask

    task automatic send_word(input logic [31:0] w, input logic v);
        send(w[31:24], v);
        send(w[23:16], v);
        send(w[15:8], v);
        send(w[7:0], v);
    endtask

    // Monitor: pops the scoreboard whenever either instance presents a word.
    initial begin
        logic [31:0] e;
        forever begin
            @(posedge clk_4f);
            #1;
            if (valid_out) begin
                if (q_m.size() == 0) chk("unexpected_valid_msb", data_out, 32'hxxxx_xxxx);
                else begin
                    e = q_m.pop_front();
                    chk("word_msb", data_out, e);
                end
            end
            if (valid_out_l) begin
                if (q_l.size() == 0) chk("unexpected_valid_lsb", data_out_l, 32'hxxxx_xxxx);
                else begin
                    e = q_l.pop_front();
                    chk("word_lsb", data_out_l, e);
                end
            end
            if (frame_err) err_seen++;
            if (valid_out && frame_err) chk("valid_and_err", {31'd0, 1'b1}, 32'd0);
        end
    end

    initial begin
        data_in  = 8'h00;
        valid_in = 1'b0;
        reset    = 1'b1;
        repeat (3) @(posedge clk_4f);
        #1;
        chk("reset_data_out", data_out, 32'h0000_0000);
        chk("reset_valid_out", {31'd0, valid_out}, 32'd0);
        chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
        chk("reset_byte_cnt", {30'd0, byte_cnt}, 32'd0);
        @(negedge clk_4f);
        reset = 1'b0;

        // Single word with byte_cnt trace 1,2,3,0.
        expect_word(32'h2E9F1305);
        send(8'h2E, 1'b1); chk("cnt_after_b0", {30'd0, byte_cnt}, 32'd1);
        send(8'h9F, 1'b1); chk("cnt_after_b1", {30'd0, byte_cnt}, 32'd2);
        send(8'h13, 1'b1); chk("cnt_after_b2", {30'd0, byte_cnt}, 32'd3);
        send(8'h05, 1'b1); chk("cnt_after_b3", {30'd0, byte_cnt}, 32'd0);
        chk("single_word", data_out, 32'h2E9F1305);
        chk("single_lsb_word", data_out_l, 32'h05139F2E);
        idle_cycle();
        chk("valid_one_cycle", {31'd0, valid_out}, 32'd0);
        chk("data_held", data_out, 32'h2E9F1305);
        idle_cycle();

        // Back-to-back words.
        expect_word(32'h2E9F3704);
        expect_word(32'h2E9F61B3);
        send_word(32'h2E9F3704, 1'b1);
        send_word(32'h2E9F61B3, 1'b1);
        idle_cycle();
        chk("no_err_back_to_back", err_seen, 32'd0);

        // Abandoned word.
        send(8'hAA, 1'b1);
        send(8'hBB, 1'b1);
        send(8'h00, 1'b0);
        chk("frame_err_pulse", {31'd0, frame_err}, 32'd1);
        chk("data_kept_after_abandon", data_out, 32'h2E9F61B3);
        chk("cnt_after_abandon", {30'd0, byte_cnt}, 32'd0);
        expect_word(32'h01020304);
        send(8'h01, 1'b1);
        chk("frame_err_single", {31'd0, frame_err}, 32'd0);
        send(8'h02, 1'b1);
        send(8'h03, 1'b1);
        send(8'h04, 1'b1);
        idle_cycle();

        // Reset mid-word.
        send(8'h11, 1'b1);
        send(8'h22, 1'b1);
        send(8'h33, 1'b1);
        #2;
        reset    = 1'b1;
        valid_in = 1'b0;
        #1;
        chk("async_clear_data", data_out, 32'h0000_0000);
        chk("async_clear_cnt", {30'd0, byte_cnt}, 32'd0);
        @(negedge clk_4f);
        reset = 1'b0;
        idle_cycle();
        chk("no_err_after_reset", {31'd0, frame_err}, 32'd0);
        expect_word(32'h44556677);
        send_word(32'h44556677, 1'b1);
        idle_cycle();

        // Loopback from a demux stream with valid pattern 1,1,0,1.
        expect_word(32'h2E9F1305);
        expect_word(32'h2E9F3704);
        expect_word(32'h2E9F85B2);
        send_word(32'h2E9F1305, 1'b1);
        send_word(32'h2E9F3704, 1'b1);
        send_word(32'h2E9F61B3, 1'b0);
        send_word(32'h2E9F85B2, 1'b1);
        repeat (3) idle_cycle();

        chk("queue_msb_empty", q_m.size(), 32'd0);
        chk("queue_lsb_empty", q_l.size(), 32'd0);
        chk("frame_err_total", err_seen, 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux8_32.md
# mux8_32

Byte-to-word assembler: collects four consecutive valid 8-bit bytes on the fast clock and presents them as one 32-bit word with a one-cycle valid strobe. It is the receive-side counterpart of the 32→8 demux, and undoes that block's byte serialisation. It runs entirely in the `clk_4f` domain, so a demux→mux loopback returns the original 32-bit stream.

## Interface
Parameters:
- `MSB_FIRST`, default 1: 1 = first byte received lands in `data_out[31:24]`; 0 = first byte lands in `data_out[7:0]`.

Ports:
- `clk_4f` input 1: byte-rate clock, the only clock.
- `reset` input 1: asynchronous, active-high reset.
- `data_in` input 8: serial byte stream.
- `valid_in` input 1: `data_in` carries a valid byte this cycle.
- `data_out` output 32: last fully assembled word, held until the next word completes.
- `valid_out` output 1: one-cycle pulse; a new word is on `data_out`.
- `frame_err` output 1: one-cycle pulse; a partial word was abandoned.
- `byte_cnt` output 2: number of bytes collected so far in the current word (0–3).

## Operation
- State machine states:
  - IDLE: no word in progress.
  - COLLECT: 1–3 bytes held.
- Internal state:
  - 24-bit shift/assembly register.
  - 2-bit `byte_cnt`.
- IDLE, `valid_in`=1:
  - Byte stored as byte 0, `byte_cnt`←1, state→COLLECT.
  - `valid_in`=0: stay in IDLE, no output change.
- COLLECT, `valid_in`=1, `byte_cnt`<3: store the byte at position `byte_cnt`, then increment `byte_cnt`.
- COLLECT, `valid_in`=1, `byte_cnt`=3 (4th byte):
  - `data_out`← the three stored bytes concatenated with `data_in`, ordered per `MSB_FIRST`.
  - `valid_out`←1, `byte_cnt`←0.
  - State→IDLE. The next cycle's byte, if valid, immediately starts a new word, so back-to-back words need no gap.
- COLLECT, `valid_in`=0:
  - Word abandoned: `frame_err`←1 for one cycle, `byte_cnt`←0, state→IDLE.
  - Stored bytes discarded; `data_out` keeps its previous word; `valid_out` stays 0.
- `valid_out` and `frame_err` are never high in the same cycle.
- Bytes are never reordered, merged across an abandoned word, or dropped while `valid_in`=1.

## Timing
- All outputs are registered and update on rising `clk_4f`.
- Latency: the 4th byte is presented in cycle N. `data_out`/`valid_out` are visible in cycle N+1, and `valid_out` falls in cycle N+2 unless another word completes.
- Throughput: one word per 4 `clk_4f` cycles, i.e. one word per `clk_f` period, when `valid_in` is held high.
- `frame_err`: the drop of `valid_in` is sampled in cycle N; `frame_err`=1 in cycle N+1 only.
- Reset values, applied asynchronously on `reset`=1, including mid-word:
  - `data_out`=32'h0, `valid_out`=0, `frame_err`=0, `byte_cnt`=0.
  - State=IDLE, assembly register cleared.
  - No `frame_err` is produced for a word cut short by reset.
- Release of `reset` is synchronous to `clk_4f`. The first edge after release with `valid_in`=1 captures byte 0.
- `valid_in` gap in IDLE: no effect, no error.

## Test plan
- Single word, `MSB_FIRST`=1:
  - Stimulus: bytes 2E, 9F, 13, 05 on 4 consecutive cycles with `valid_in`=1.
  - Response: `data_out`=32'h2E9F1305 and `valid_out`=1 for exactly one cycle, the cycle after byte 05. `byte_cnt` sequence 1,2,3,0.
- Back-to-back words:
  - Stimulus: 8 consecutive valid bytes 2E 9F 37 04 2E 9F 61 B3.
  - Response: `valid_out` pulses twice, 4 cycles apart, with 32'h2E9F3704 then 32'h2E9F61B3. `frame_err` never asserted.
- Abandoned word:
  - Stimulus: bytes AA, BB valid, then `valid_in`=0, then 01 02 03 04 valid.
  - Response: `frame_err` pulses once. `data_out` unchanged by AA/BB. Next `valid_out` shows 32'h01020304.
- Reset mid-word:
  - Stimulus: `reset` pulsed asynchronously after 3 bytes 11 22 33, then 44 55 66 77 sent.
  - Response: immediate clear of `data_out`=0 and `byte_cnt`=0. No `frame_err`. Then 32'h44556677.
- `MSB_FIRST`=0:
  - Stimulus: bytes 2E 9F 13 05.
  - Response: `data_out`=32'h05139F2E.
- Loopback:
  - Stimulus: 32→8 demux driven with 32'h2E9F1305, +'h23FF, +'h2AAF per `clk_f`, with valid pattern 1,1,0,1; demux output fed into this block.
  - Response: only the valid words reappear on `data_out`, in order and bit-exact, each with one `valid_out` pulse.
